// File: rtl/cartesian_to_polar_if.sv
// ============================================================================
// cartesian_to_polar_if : start/done request and result bundle for cartesian_to_polar
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cartesian_to_polar_if;
  logic        start;
  logic [8:0]  x_value;
  logic [8:0]  y_value;
  logic [11:0] r_theta;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output x_value,
    output y_value,
    input  r_theta,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  x_value,
    input  y_value,
    output r_theta,
    output busy,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/cartesian_to_polar.sv
// ============================================================================
// cartesian_to_polar : sign-magnitude (x,y) to packed {theta[3:0], r[7:0]} word
// Revision: 1.0
// ============================================================================
`default_nettype none

module cartesian_to_polar (
  input  wire logic            clock,
  input  wire logic            reset_n,
  cartesian_to_polar_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd8;
  localparam logic [3:0] NUM_THR   = 4'd6;

  state_t       state_q,   state_d;
  logic [7:0]   x_mag_q,   x_mag_d;
  logic         x_neg_q,   x_neg_d;
  logic [7:0]   y_mag_q,   y_mag_d;
  logic [17:0]  rad_q,     rad_d;
  logic [8:0]   root_q,    root_d;
  logic [9:0]   rem_q,     rem_d;
  logic [2:0]   q_cnt_q,   q_cnt_d;
  logic [3:0]   iter_q,    iter_d;
  logic [11:0]  r_theta_q, r_theta_d;

  logic [11:0]  rem_shift;
  logic [11:0]  trial;
  logic [10:0]  thr;
  logic [18:0]  y_scaled;
  logic [18:0]  x_scaled;
  logic [3:0]   theta;

  always_comb begin
    state_d   = state_q;
    x_mag_d   = x_mag_q;
    x_neg_d   = x_neg_q;
    y_mag_d   = y_mag_q;
    rad_d     = rad_q;
    root_d    = root_q;
    rem_d     = rem_q;
    q_cnt_d   = q_cnt_q;
    iter_d    = iter_q;
    r_theta_d = r_theta_q;

    // One restoring square-root step: bring down the next radicand bit pair
    rem_shift = {rem_q, rad_q[17:16]};
    trial     = {1'b0, root_q, 2'b01};

    case (iter_q)
      4'd0:    thr = 11'd34;
      4'd1:    thr = 11'd106;
      4'd2:    thr = 11'd196;
      4'd3:    thr = 11'd334;
      4'd4:    thr = 11'd618;
      4'd5:    thr = 11'd1944;
      default: thr = 11'd0;
    endcase
    y_scaled = {3'b000, y_mag_q, 8'h00};
    x_scaled = 19'(x_mag_q) * 19'(thr);
    theta    = x_neg_q ? 4'(4'd12 - {1'b0, q_cnt_q}) : {1'b0, q_cnt_q};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = LOAD;
          x_mag_d = bus.x_value[7:0];
          // Negative zero is folded to positive; a negative y lands on the x axis
          x_neg_d = bus.x_value[8] && (bus.x_value[7:0] != 8'd0);
          y_mag_d = bus.y_value[8] ? 8'd0 : bus.y_value[7:0];
        end
      end
      LOAD: begin
        state_d = CALC;
        rad_d   = {1'b0, 17'(x_mag_q) * 17'(x_mag_q) + 17'(y_mag_q) * 17'(y_mag_q)};
        root_d  = 9'd0;
        rem_d   = 10'd0;
        q_cnt_d = 3'd0;
        iter_d  = 4'd0;
      end
      CALC: begin
        rad_d  = {rad_q[15:0], 2'b00};
        iter_d = iter_q + 4'd1;
        if (rem_shift >= trial) begin
          rem_d  = 10'(rem_shift - trial);
          root_d = {root_q[7:0], 1'b1};
        end else begin
          rem_d  = rem_shift[9:0];
          root_d = {root_q[7:0], 1'b0};
        end
        if ((iter_q < NUM_THR) && (y_scaled > x_scaled)) begin
          q_cnt_d = q_cnt_q + 3'd1;
        end
        if (iter_q == LAST_ITER) begin
          state_d   = DONE;
          r_theta_d = {theta, root_d[8] ? 8'hFF : root_d[7:0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_mag_q   <= 8'd0;
      x_neg_q   <= 1'b0;
      y_mag_q   <= 8'd0;
      rad_q     <= 18'd0;
      root_q    <= 9'd0;
      rem_q     <= 10'd0;
      q_cnt_q   <= 3'd0;
      iter_q    <= 4'd0;
      r_theta_q <= 12'h000;
    end else begin
      state_q   <= state_d;
      x_mag_q   <= x_mag_d;
      x_neg_q   <= x_neg_d;
      y_mag_q   <= y_mag_d;
      rad_q     <= rad_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
      q_cnt_q   <= q_cnt_d;
      iter_q    <= iter_d;
      r_theta_q <= r_theta_d;
    end
  end

  assign bus.r_theta = r_theta_q;
  assign bus.busy    = (state_q == LOAD) || (state_q == CALC);
  assign bus.done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_cartesian_to_polar.sv
// ============================================================================
// tb_cartesian_to_polar : directed and swept vectors with a queued scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cartesian_to_polar;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  cartesian_to_polar_if bus ();

  cartesian_to_polar dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [11:0] exp;
    int          start_cyc;
  } sb_t;

  sb_t         sb_q[$];
  logic [11:0] last_exp;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model(input logic [8:0] xv, input logic [8:0] yv);
    int thr_tab [6];
    int xm, ym, s, r, q, th;
    bit xneg;
    thr_tab = '{34, 106, 196, 334, 618, 1944};
    xm   = int'(xv[7:0]);
    xneg = xv[8] && (xm != 0);
    ym   = yv[8] ? 0 : int'(yv[7:0]);
    s    = xm * xm + ym * ym;
    r    = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    if (r > 255) r = 255;
    q = 0;
    for (int i = 0; i < 6; i++) if (ym * 256 > xm * thr_tab[i]) q++;
    th = xneg ? 12 - q : q;
    return {4'(th), 8'(r)};
  endfunction

  // Monitor: every done pops one expectation; otherwise the result must hold
  always @(negedge clock) begin
    sb_t e;
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {20'd0, bus.r_theta}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("r_theta", {20'd0, bus.r_theta}, {20'd0, e.exp});
        chk("latency", 32'(cyc + 1 - e.start_cyc), 32'd11);
        last_exp = e.exp;
      end
    end else begin
      chk("r_theta_hold", {20'd0, bus.r_theta}, {20'd0, last_exp});
    end
  end

  task automatic issue(input logic [8:0] xv, input logic [8:0] yv, input logic [11:0] exp);
    sb_t e;
    @(negedge clock);
    bus.x_value = xv;
    bus.y_value = yv;
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    bus.start   = 1'b0;
    e.exp       = exp;
    e.start_cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic back_to_back(input logic [8:0] x1, input logic [8:0] y1, input logic [11:0] e1,
                              input logic [8:0] x2, input logic [8:0] y2, input logic [11:0] e2);
    int  n;
    sb_t e;
    issue(x1, y1, e1);
    n = 0;
    while (!bus.done && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!bus.done) begin
      chk("b2b_done_timeout", 32'd0, 32'd1);
    end else begin
      bus.x_value = x2;
      bus.y_value = y2;
      bus.start   = 1'b1;
      @(posedge clock);
      #1;
      bus.start   = 1'b0;
      e.exp       = e2;
      e.start_cyc = cyc;
      sb_q.push_back(e);
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] xv;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    last_exp    = 12'h000;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.x_value = 9'd0;
    bus.y_value = 9'd0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_r_theta", {20'd0, bus.r_theta}, 32'h0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Axis points
    issue(9'h0FF, 9'd0,   12'h0FF); drain();
    issue(9'h1FF, 9'd0,   12'hCFF); drain();
    issue(9'h000, 9'd100, 12'h664); drain();
    issue(9'h000, 9'd0,   12'h000); drain();

    // Off-axis
    issue(9'd3,   9'd4,   12'h405); drain();
    issue(9'h103, 9'd4,   12'h805); drain();
    issue(9'd100, 9'd100, 12'h38D); drain();

    // Saturation and normalisation
    issue(9'd200, 9'd200, 12'h3FF); drain();
    issue(9'h100, 9'd50,  12'h632); drain();
    issue(9'd20,  9'h11E, 12'h014); drain();

    // Start pulses during CALC are ignored
    issue(9'd3, 9'd4, 12'h405);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("busy_in_calc", {31'd0, bus.busy}, 32'd1);
      bus.x_value = 9'd77;
      bus.y_value = 9'd11;
      bus.start   = 1'b1;
      @(posedge clock);
      #1;
      bus.start   = 1'b0;
      @(posedge clock);
    end
    drain();
    repeat (15) @(posedge clock);

    // Back-to-back via start in DONE
    back_to_back(9'd100, 9'd100, 12'h38D, 9'h1FF, 9'd0, 12'hCFF);
    repeat (3) @(posedge clock);

    // Reset mid-CALC aborts with no done
    issue(9'd3, 9'd4, 12'h405);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_r_theta", {20'd0, bus.r_theta}, 32'h0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    sb_q.delete();
    last_exp = 12'h000;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (15) @(posedge clock);

    // Sweep against the reference model
    for (int xi = -255; xi <= 255; xi += 17) begin
      for (int yi = 0; yi <= 255; yi += 17) begin
        xv = (xi < 0) ? {1'b1, 8'(-xi)} : {1'b0, 8'(xi)};
        issue(xv, 9'(yi), model(xv, 9'(yi)));
        drain();
      end
    end

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
